onehot_decoder_seq: RTL
=======================

# onehot_decoder_seq

Sequential 3-to-8 one-hot decoder. It is the receive-side counterpart to the 8-to-3 `priority_encoder`. The block accepts a 3-bit code over a valid/ready handshake and drives the matching one-hot line for a programmable number of cycles. It then forces one all-zero gap cycle, so that two consecutive one-hot outputs never overlap (break-before-make). It sits downstream of the encoder, or of any block producing a 3-bit select, and drives one-hot enables or strobes into the datapath.

## Interface
- `N_SEL`, default 3: code width.
- `OUT_W`, default 8: one-hot width; must equal 2**N_SEL.
- `HOLD_W`, default 4: width of the hold-length input.

- `clk` in 1: single clock; all state updates on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `q` in N_SEL: code to decode; sampled on accept.
- `in_valid` in 1: `q` and `hold_len` are valid.
- `in_ready` out 1: block can accept a code this cycle.
- `hold_len` in HOLD_W: number of cycles to hold the one-hot output; sampled on accept.
- `d` out OUT_W: registered one-hot output; all-zero when not driving.
- `busy` out 1: high in DRIVE and GAP.
- `done` out 1: single-cycle pulse in the GAP cycle.

## Operation
- The state machine has three states: IDLE, DRIVE, GAP. State, `d`, the hold counter, the code register and `done` are all registers.
- Reset (`rst`=1 at an edge) sets the following, with priority over every other event, including mid-DRIVE or mid-GAP:
  - state to IDLE;
  - `d` to 8'h00;
  - `done` to 0;
  - hold counter to 0.
- After that edge, `in_ready`=1 and `busy`=0.
- `in_ready` = (state==IDLE) and `busy` = (state!=IDLE). Both are decoded from registered state only, with no combinational path from `in_valid`.
- IDLE:
  - `d`=0.
  - Accept occurs when `in_valid` && `in_ready` at an edge. On accept: latch `q`; load the counter with `hold_len`, or 1 if `hold_len`==0; set `d` <= 1<<q; go to DRIVE.
  - With no accept, remain in IDLE.
- DRIVE:
  - `d` holds 1<<q_latched; exactly one bit is set.
  - The counter decrements each edge. On the edge where the counter==1, `d` <= 0, `done` <= 1, and the state goes to GAP.
  - `in_valid` and `q` are ignored; changes to `q`/`hold_len` after accept have no effect.
- GAP:
  - `d`=0 and `done`=1 for exactly one cycle.
  - The next edge sets `done` <= 0 and the state goes to IDLE.
- Width rules:
  - The counter is HOLD_W bits, so the maximum hold is 2**HOLD_W−1 (15) cycles.
  - `hold_len`=0 is treated as 1; there is never a zero-length drive.
  - Code wrap: all 8 codes 0..7 are legal; there is no out-of-range case.
- Unreachable state encodings recover to IDLE with `d`=0.

## Timing
- Accept at edge T:
  - `d` is one-hot from T to T+H, for H cycles, where H=max(hold_len,1).
  - GAP (`d`=0, `done`=1) is the cycle after edge T+H.
  - IDLE (`in_ready`=1) follows edge T+H+1.
- The earliest next accept is edge T+H+2. The minimum spacing between the rising edges of two consecutive one-hot pulses is H+2 cycles, which guarantees at least 1 zero cycle between them.
- Latency from accept to `d` is 1 cycle (registered output).
- `in_valid` held high continuously produces back-to-back decodes at the maximum rate. Each is separated by GAP and one IDLE cycle.
- Reset asserted in the same cycle as `in_valid`: reset wins and the code is not accepted.

## Test plan
- Reset, then `q`=3'd5, `hold_len`=3, one-cycle valid:
  - `d`=8'h20 for exactly 3 cycles starting 1 cycle after accept;
  - then 8'h00 with `done`=1 for 1 cycle;
  - `in_ready` returns 1 the cycle after.
- Sweep `q`=0..7 with `hold_len`=1 and `in_valid` held high:
  - `d` sequence is 01,00,00,02,00,00,04 … 80;
  - never two bits set; never two one-hot cycles adjacent across codes.
- `hold_len`=0 with `q`=3'd7 → `d`=8'h80 for exactly 1 cycle; `hold_len`=15 → 15 cycles.
- Change `q` from 2 to 6 during DRIVE (`hold_len`=4) → `d` stays 8'h04 for all 4 cycles; `in_ready`=0 throughout DRIVE and GAP.
- Assert `rst` in the second DRIVE cycle of `q`=3'd1, `hold_len`=8:
  - next edge gives `d`=8'h00, `done`=0, `busy`=0, `in_ready`=1;
  - no GAP/`done` pulse is emitted.
- `rst`=1 together with `in_valid`=1, `q`=3'd4 → no decode occurs; `d` stays 8'h00.

Source files
------------

// File: rtl/onehot_decoder_seq.sv
// -----------------------------------------------------------------------------
// onehot_decoder_seq
//
// Sequential N_SEL-to-OUT_W one-hot decoder with break-before-make spacing.
// A code accepted over a valid/ready handshake drives its one-hot line for a
// programmable number of cycles, then one forced all-zero GAP cycle, so two
// consecutive one-hot pulses never touch.
//
// Parameters
//   N_SEL    code width
//   OUT_W    one-hot width, must equal 2**N_SEL
//   HOLD_W   width of the hold-length input and of the hold counter
//
// Ports
//   clk       clock, all state changes on the rising edge
//   rst       synchronous active-high reset, highest priority
//   q         code to decode, sampled on accept
//   in_valid  q / hold_len are valid
//   in_ready  block can accept a code this cycle (state == IDLE)
//   hold_len  number of cycles to drive the one-hot line (0 behaves as 1)
//   d         registered one-hot output, all-zero when not driving
//   busy      high in DRIVE and GAP
//   done      single-cycle pulse during the GAP cycle
// -----------------------------------------------------------------------------
module onehot_decoder_seq #(
  parameter int N_SEL  = 3,
  parameter int OUT_W  = 8,
  parameter int HOLD_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [N_SEL-1:0]  q,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [HOLD_W-1:0] hold_len,
  output logic [OUT_W-1:0]  d,
  output logic              busy,
  output logic              done
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    GAP   = 2'd2
  } state_t;

  localparam logic [HOLD_W-1:0] CNT_ZERO = {HOLD_W{1'b0}};
  localparam logic [HOLD_W-1:0] CNT_ONE  = {{(HOLD_W-1){1'b0}}, 1'b1};
  localparam logic [OUT_W-1:0]  D_ZERO   = {OUT_W{1'b0}};

  state_t              state_r;
  logic [HOLD_W-1:0]   cnt_r;
  logic [N_SEL-1:0]    code_r;

  // One-hot image of a code: bit 'code' set, all others clear.
  function automatic logic [OUT_W-1:0] onehot_of(input logic [N_SEL-1:0] code);
    logic [OUT_W-1:0] base;
    base      = {{(OUT_W-1){1'b0}}, 1'b1};
    onehot_of = base << code;
  endfunction

  // Effective hold length: a zero request still drives for one cycle.
  function automatic logic [HOLD_W-1:0] eff_hold(input logic [HOLD_W-1:0] len);
    if (len == CNT_ZERO) begin
      eff_hold = CNT_ONE;
    end else begin
      eff_hold = len;
    end
  endfunction

  // Handshake and status flags decode registered state only, so there is no
  // combinational path from in_valid to in_ready.
  assign in_ready = (state_r == IDLE);
  assign busy     = (state_r != IDLE);

  // Control FSM with registered one-hot output, done pulse and hold counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
      d       <= D_ZERO;
      done    <= 1'b0;
      cnt_r   <= CNT_ZERO;
      code_r  <= {N_SEL{1'b0}};
    end else begin
      case (state_r)
        IDLE: begin
          done <= 1'b0;
          if (in_valid) begin
            code_r  <= q;
            cnt_r   <= eff_hold(hold_len);
            d       <= onehot_of(q);
            state_r <= DRIVE;
          end else begin
            d       <= D_ZERO;
            state_r <= IDLE;
          end
        end

        DRIVE: begin
          // A counter of 0 can only come from corruption; end the drive
          // rather than wrapping to a 2**HOLD_W-1 cycle hold.
          if (cnt_r <= CNT_ONE) begin
            d       <= D_ZERO;
            done    <= 1'b1;
            cnt_r   <= CNT_ZERO;
            state_r <= GAP;
          end else begin
            d       <= onehot_of(code_r);
            done    <= 1'b0;
            cnt_r   <= cnt_r - CNT_ONE;
            state_r <= DRIVE;
          end
        end

        GAP: begin
          d       <= D_ZERO;
          done    <= 1'b0;
          cnt_r   <= CNT_ZERO;
          state_r <= IDLE;
        end

        default: begin
          // Unreachable encoding: fall back to a quiet IDLE.
          d       <= D_ZERO;
          done    <= 1'b0;
          cnt_r   <= CNT_ZERO;
          state_r <= IDLE;
        end
      endcase
    end
  end

endmodule
